// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline interlock controller.
//   state_e        : RUN/HALT state encoding
//   CNT_W_DEFAULT  : default width of the performance counters
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipeline_interlock_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (value -> 0)
//   inc    : count enable; holds at all-ones instead of wrapping
//   clr    : synchronous clear, wins over inc
//   value  : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock controller: turns load-use stall and EX mispredict
// requests into PC / IF-ID / ID-EX enable and clear controls, runs the
// RUN/HALT syscall state machine, and keeps saturating performance counters
// plus a sticky watchdog for over-long stall runs.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   Stall_PC_ID         : load-use stall request (same cycle)
//   Mispredict          : EX redirect (same cycle), beats Stall_PC_ID
//   Halt, Go            : enter HALT / resume pulse
//   CntClr              : synchronous clear of counters and Stall_Err
//   PC_EN, IFID_EN      : register load enables
//   IFID_CLR, IDEX_CLR  : bubble-insert clears
//   Halted, Stall_Err   : status
//   CycleCnt, StallCnt, FlushCnt : saturating counters
module pipeline_interlock_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Stall_PC_ID,
    input  logic             Mispredict,
    input  logic             Halt,
    input  logic             Go,
    input  logic             CntClr,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IFID_CLR,
    output logic             IDEX_CLR,
    output logic             Halted,
    output logic             Stall_Err,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // Wide enough to hold MAX_STALL+1, the saturation point of the run count.
    localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;

    logic in_run;
    logic flush_app;
    logic stall_app;

    always_comb begin
        in_run    = (state_q == ST_RUN);
        flush_app = in_run && Mispredict;
        stall_app = in_run && !Mispredict && Stall_PC_ID;

        state_d = state_q;
        run_d   = '0;
        err_d   = err_q;

        PC_EN    = 1'b1;
        IFID_EN  = 1'b1;
        IFID_CLR = 1'b0;
        IDEX_CLR = 1'b0;
        Halted   = 1'b0;

        // Outputs are forced to a safe value for as long as reset is held,
        // not just after the flops have cleared.
        if (!RST_N) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IFID_CLR = 1'b1;
            IDEX_CLR = 1'b1;
        end else if (!in_run) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IDEX_CLR = 1'b1;
            Halted   = 1'b1;
        end else if (Mispredict) begin
            IFID_CLR = 1'b1;
            IDEX_CLR = 1'b1;
        end else if (Stall_PC_ID) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IDEX_CLR = 1'b1;
        end

        unique case (state_q)
            ST_RUN:  if (Halt)         state_d = ST_HALT;
            ST_HALT: if (Go && !Halt)  state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase

        if (stall_app) begin
            run_d = (run_q >= RUN_SAT) ? RUN_SAT : run_q + RUN_W'(1);
        end

        if (CntClr) begin
            err_d = 1'b0;
        end else if (stall_app && (run_q >= RUN_MAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign Stall_Err = err_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (in_run),
        .clr   (CntClr),
        .value (CycleCnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (stall_app),
        .clr   (CntClr),
        .value (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (flush_app),
        .clr   (CntClr),
        .value (FlushCnt)
    );

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
module tb_pipeline_interlock_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, mis = 1'b0, halt = 1'b0, go = 1'b0, clr = 1'b0;

    logic        a_pc, a_ifen, a_ifclr, a_idclr, a_halted, a_err;
    logic [15:0] a_cyc, a_st, a_fl;
    logic        b_pc, b_ifen, b_ifclr, b_idclr, b_halted, b_err;
    logic [3:0]  b_cyc, b_st, b_fl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_interlock_ctrl #(.CNT_W(16), .MAX_STALL(4)) u_dut16 (
        .CLK(clk), .RST_N(rst_n), .Stall_PC_ID(stall), .Mispredict(mis),
        .Halt(halt), .Go(go), .CntClr(clr),
        .PC_EN(a_pc), .IFID_EN(a_ifen), .IFID_CLR(a_ifclr), .IDEX_CLR(a_idclr),
        .Halted(a_halted), .Stall_Err(a_err),
        .CycleCnt(a_cyc), .StallCnt(a_st), .FlushCnt(a_fl)
    );

    pipeline_interlock_ctrl #(.CNT_W(4), .MAX_STALL(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .Stall_PC_ID(stall), .Mispredict(mis),
        .Halt(halt), .Go(go), .CntClr(clr),
        .PC_EN(b_pc), .IFID_EN(b_ifen), .IFID_CLR(b_ifclr), .IDEX_CLR(b_idclr),
        .Halted(b_halted), .Stall_Err(b_err),
        .CycleCnt(b_cyc), .StallCnt(b_st), .FlushCnt(b_fl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // outs = {PC_EN, IFID_EN, IFID_CLR, IDEX_CLR}; counters/err are after the edge
    typedef struct {
        bit       halt, go, stall, mis, clr;
        bit [3:0] outs;
        bit       hlt;
        int       cyc, st, fl;
        bit       err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit h, input bit g, input bit s, input bit m, input bit c,
                       input bit [3:0] o, input bit hl, input int cy, input int st_n,
                       input int fl_n, input bit e);
        vec_t v;
        v.halt = h; v.go = g; v.stall = s; v.mis = m; v.clr = c;
        v.outs = o; v.hlt = hl; v.cyc = cy; v.st = st_n; v.fl = fl_n; v.err = e;
        tv.push_back(v);
    endtask

    task automatic chk_comb(input string tag, input bit [3:0] o, input bit hl);
        chk({tag, ".ctl16"}, {28'd0, a_pc, a_ifen, a_ifclr, a_idclr}, {28'd0, o});
        chk({tag, ".ctl4"},  {28'd0, b_pc, b_ifen, b_ifclr, b_idclr}, {28'd0, o});
        chk({tag, ".halted"}, {31'd0, a_halted}, {31'd0, hl});
        chk({tag, ".halted4"}, {31'd0, b_halted}, {31'd0, hl});
    endtask

    task automatic chk_cnt(input string tag, input int cy, input int st_n, input int fl_n, input bit e);
        chk({tag, ".cyc16"}, {16'd0, a_cyc}, sat(cy, 65535));
        chk({tag, ".stall16"}, {16'd0, a_st}, sat(st_n, 65535));
        chk({tag, ".flush16"}, {16'd0, a_fl}, sat(fl_n, 65535));
        chk({tag, ".cyc4"}, {28'd0, b_cyc}, sat(cy, 15));
        chk({tag, ".stall4"}, {28'd0, b_st}, sat(st_n, 15));
        chk({tag, ".flush4"}, {28'd0, b_fl}, sat(fl_n, 15));
        chk({tag, ".err16"}, {31'd0, a_err}, {31'd0, e});
        chk({tag, ".err4"}, {31'd0, b_err}, {31'd0, e});
    endtask

    // Reference model state: plain integers following the behavioural rules.
    bit m_halted;
    int m_cyc, m_st, m_fl, m_run;
    bit m_err;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- reset values while RST_N is held low ----
        #1;
        chk_comb("reset", 4'b0011, 1'b0);
        chk_cnt("reset", 0, 0, 0, 1'b0);
        #20;

        // ---- directed table ----
        for (int i = 0; i < 10; i++) add(0,0,0,0,0, 4'b1100, 0, i + 1, 0, 0, 0);
        add(0,0,1,0,0, 4'b0001, 0, 11, 1, 0, 0);          // single stall
        add(0,0,1,1,0, 4'b1111, 0, 12, 1, 1, 0);          // mispredict beats stall
        for (int k = 0; k < 5; k++)
            add(0,0,1,0,0, 4'b0001, 0, 13 + k, 2 + k, 1, k == 4); // 5th stall trips watchdog
        add(0,0,0,0,0, 4'b1100, 0, 18, 6, 1, 1);          // sticky
        add(0,0,0,0,1, 4'b1100, 0, 0, 0, 0, 0);           // CntClr beats cycle increment
        add(1,0,0,0,0, 4'b1100, 0, 1, 0, 0, 0);           // halt sampled: still RUN outputs
        add(0,0,0,1,0, 4'b0001, 1, 1, 0, 0, 0);           // mispredict ignored in HALT
        add(0,0,1,0,0, 4'b0001, 1, 1, 0, 0, 0);           // stall ignored in HALT
        add(1,1,0,0,0, 4'b0001, 1, 1, 0, 0, 0);           // go+halt: stay halted
        add(0,1,0,0,0, 4'b0001, 1, 1, 0, 0, 0);           // go: resume next cycle
        add(0,0,0,0,0, 4'b1100, 0, 2, 0, 0, 0);
        add(1,1,0,0,0, 4'b1100, 0, 3, 0, 0, 0);           // halt wins in RUN
        add(0,1,0,0,0, 4'b0001, 1, 3, 0, 0, 0);
        add(0,1,0,0,0, 4'b1100, 0, 4, 0, 0, 0);           // go in RUN ignored
        add(0,0,1,0,1, 4'b0001, 0, 0, 0, 0, 0);           // CntClr beats stall increment
        add(0,0,0,0,0, 4'b1100, 0, 1, 0, 0, 0);

        foreach (tv[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            halt = tv[i].halt; go = tv[i].go; stall = tv[i].stall;
            mis = tv[i].mis; clr = tv[i].clr;
            #1;
            chk_comb($sformatf("vec%0d", i), tv[i].outs, tv[i].hlt);
            @(posedge clk);
            #1;
            chk_cnt($sformatf("vec%0d", i), tv[i].cyc, tv[i].st, tv[i].fl, tv[i].err);
        end

        // ---- saturation of the narrow counter ----
        @(negedge clk);
        halt = 0; go = 0; stall = 0; mis = 0; clr = 0;
        repeat (20) @(posedge clk);
        #1;
        chk_cnt("sat", 21, 0, 0, 1'b0);

        // ---- reset dropped mid-halt ----
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        #1;
        chk_comb("prehalt", 4'b0001, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_comb("midhalt_rst", 4'b0011, 1'b0);
        chk_cnt("midhalt_rst", 0, 0, 0, 1'b0);

        // ---- randomized run against the reference model ----
        @(negedge clk);
        @(negedge clk);
        m_halted = 0; m_cyc = 0; m_st = 0; m_fl = 0; m_run = 0; m_err = 0;
        for (int n = 0; n < 600; n++) begin
            bit [3:0] exp_o;
            bit       run_mode, is_flush, is_stall;
            @(negedge clk);
            rst_n = 1'b1;
            stall = ($urandom_range(0, 99) < 45);
            mis   = ($urandom_range(0, 99) < 12);
            halt  = ($urandom_range(0, 99) < 4);
            go    = ($urandom_range(0, 99) < 30);
            clr   = ($urandom_range(0, 99) < 2);

            run_mode = !m_halted;
            is_flush = run_mode && mis;
            is_stall = run_mode && !mis && stall;
            if (!run_mode)     exp_o = 4'b0001;
            else if (is_flush) exp_o = 4'b1111;
            else if (is_stall) exp_o = 4'b0001;
            else               exp_o = 4'b1100;
            #1;
            chk_comb($sformatf("rnd%0d", n), exp_o, m_halted);

            @(posedge clk);
            if (clr) begin
                m_cyc = 0; m_st = 0; m_fl = 0; m_err = 0;
            end else begin
                m_cyc += run_mode;
                m_st  += is_stall;
                m_fl  += is_flush;
                if (is_stall && m_run + 1 > 4) m_err = 1;
            end
            m_run = is_stall ? sat(m_run + 1, 5) : 0;
            if (run_mode && halt)                  m_halted = 1;
            else if (!run_mode && go && !halt)     m_halted = 0;
            #1;
            chk_cnt($sformatf("rnd%0d", n), m_cyc, m_st, m_fl, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
